// File: rtl/mfe_lcd_charbuf_refresher.sv
// Character-buffer front end for HD44780-class LCDs: runs the init sequence, then
// rewrites only dirty rows, round-robin, over a byte-level cmd/dat/vld/lwt/ready link.
module mfe_lcd_charbuf_refresher #(
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int ROW_W     = 2,
  parameter int COL_W     = 6,
  parameter int CURSOR_ON = 0,
  parameter int BLINK_ON  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COL_W-1:0] wr_col,
  input  logic [7:0]       wr_data,
  input  logic             refresh,
  output logic             init_done,
  output logic             busy,
  output logic             lc_cmd,
  output logic [7:0]       lc_dat,
  output logic             lc_vld,
  output logic             lc_lwt,
  input  logic             lc_ready
);

  localparam int RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = $clog2(COLS);
  localparam int AW  = $clog2(ROWS * COLS);
  localparam logic [7:0] FUNC_SET = (ROWS == 1) ? 8'h30 : 8'h38;
  localparam logic [7:0] DISP_CTL = 8'h0C | ((CURSOR_ON != 0) ? 8'h02 : 8'h00)
                                          | ((BLINK_ON  != 0) ? 8'h01 : 8'h00);

  typedef enum logic [2:0] {INIT, IDLE, ADDR, CHAR, WAIT} state_t;

  state_t          state, state_n;
  logic [1:0]      step, step_n;
  logic [RIW-1:0]  row, row_n, last_row, last_row_n, sel_row;
  logic [CIW-1:0]  col, col_n;
  logic            init_done_n, vld_n, cmd_n, lwt_n, clr_en, sel_found, ready_q, wr_ok;
  logic [7:0]      dat_n;
  logic [ROWS-1:0] dirty, dirty_n, dirty_set, dirty_clr;
  logic [AW-1:0]   wr_idx, rd_idx;
  logic [7:0]      char_buf [ROWS*COLS];

  function automatic logic [7:0] init_cmd(input logic [1:0] s);
    case (s)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_CTL;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // DDRAM row starts: rows 2/3 continue lines 0/1 after COLS characters
  function automatic logic [7:0] row_base(input logic [RIW-1:0] r);
    case (int'(r))
      0:       return 8'h00;
      1:       return 8'h40;
      2:       return 8'(COLS);
      default: return 8'(64 + COLS);
    endcase
  endfunction

  always_comb begin
    wr_ok  = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
    wr_idx = AW'(int'(wr_row) * COLS + int'(wr_col));
    rd_idx = AW'(int'(row) * COLS + int'(col));
  end

  // Descending scan so the nearest dirty row after last_row is the one kept
  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    sel_found = 1'b0;
    sel_row   = '0;
    for (int i = ROWS; i >= 1; i--) begin
      idx = int'(last_row) + i;
      if (idx >= ROWS) idx = idx - ROWS;
      for (int r = 0; r < ROWS; r++) begin
        if (r == idx && dirty[r]) begin
          sel_found = 1'b1;
          sel_row   = RIW'(r);
        end
      end
    end
  end

  always_comb begin
    state_n     = state;
    step_n      = step;
    row_n       = row;
    col_n       = col;
    last_row_n  = last_row;
    init_done_n = init_done;
    vld_n       = lc_vld;
    cmd_n       = lc_cmd;
    dat_n       = lc_dat;
    lwt_n       = lc_lwt;
    clr_en      = 1'b0;
    case (state)
      INIT, ADDR, CHAR: begin
        if (!lc_vld) begin
          vld_n = 1'b1;
          cmd_n = (state != CHAR);
          lwt_n = (state == INIT);
          if (state == INIT)      dat_n = init_cmd(step);
          else if (state == ADDR) dat_n = 8'h80 | row_base(row);
          else                    dat_n = char_buf[rd_idx];
        end else if (lc_ready) begin
          vld_n   = 1'b0;
          state_n = WAIT;
        end
      end
      IDLE: begin
        if (sel_found) begin
          clr_en  = 1'b1;
          row_n   = sel_row;
          state_n = ADDR;
        end
      end
      WAIT: begin
        if (!ready_q && lc_ready) begin
          if (!init_done) begin
            if (step == 2'd3) begin
              init_done_n = 1'b1;
              state_n     = IDLE;
            end else begin
              step_n  = step + 2'd1;
              state_n = INIT;
            end
          end else if (lc_cmd) begin
            col_n   = '0;
            state_n = CHAR;
          end else if (col == CIW'(COLS - 1)) begin
            last_row_n = row;
            state_n    = IDLE;
          end else begin
            col_n   = col + 1'b1;
            state_n = CHAR;
          end
        end
      end
      default: state_n = INIT;
    endcase
  end

  // A write landing on the row being cleared keeps it dirty
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      dirty_set[r] = refresh || (wr_ok && int'(wr_row) == r);
      dirty_clr[r] = clr_en && int'(sel_row) == r;
    end
    dirty_n = (dirty & ~dirty_clr) | dirty_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      step      <= 2'd0;
      row       <= '0;
      col       <= '0;
      last_row  <= RIW'(ROWS - 1);
      init_done <= 1'b0;
      lc_vld    <= 1'b0;
      lc_cmd    <= 1'b0;
      lc_dat    <= 8'h00;
      lc_lwt    <= 1'b0;
      busy      <= 1'b1;
      ready_q   <= 1'b0;
      dirty     <= '1;
    end else begin
      state     <= state_n;
      step      <= step_n;
      row       <= row_n;
      col       <= col_n;
      last_row  <= last_row_n;
      init_done <= init_done_n;
      lc_vld    <= vld_n;
      lc_cmd    <= cmd_n;
      lc_dat    <= dat_n;
      lc_lwt    <= lwt_n;
      busy      <= ~init_done_n | (state_n != IDLE) | (|dirty_n);
      ready_q   <= lc_ready;
      dirty     <= dirty_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS * COLS; i++) char_buf[i] <= 8'h20;
    end else if (wr_ok) begin
      char_buf[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_mfe_lcd_charbuf_refresher.sv
// Scoreboard bench: instance A is 2x16 with full byte checking, instance B is 4x20
// with address-order checking; slow downstream models hold ready low after each accept.
module tb_mfe_lcd_charbuf_refresher;
  localparam int HOLD_A = 5;
  localparam int HOLD_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, wr_en_a = 1'b0, refresh_a = 1'b0, ready_a = 1'b1;
  logic [1:0] wr_row_a = '0;
  logic [5:0] wr_col_a = '0;
  logic [7:0] wr_data_a = '0;
  logic       init_done_a, busy_a, cmd_a, vld_a, lwt_a;
  logic [7:0] dat_a;

  logic       rst_b = 1'b1, wr_en_b = 1'b0, refresh_b = 1'b0, ready_b = 1'b1;
  logic [1:0] wr_row_b = '0;
  logic [5:0] wr_col_b = '0;
  logic [7:0] wr_data_b = '0;
  logic       init_done_b, busy_b, cmd_b, vld_b, lwt_b;
  logic [7:0] dat_b;

  int vectors = 0, miscompares = 0;
  logic [9:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] model_a [2][16];
  int cap_a = 0, addr_b = 0, cnt_a = 0, cnt_b = 0;
  bit pend_a = 0, pend_b = 0;

  mfe_lcd_charbuf_refresher #(.ROWS(2), .COLS(16), .ROW_W(2), .COL_W(6)) dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_row(wr_row_a), .wr_col(wr_col_a),
    .wr_data(wr_data_a), .refresh(refresh_a), .init_done(init_done_a), .busy(busy_a),
    .lc_cmd(cmd_a), .lc_dat(dat_a), .lc_vld(vld_a), .lc_lwt(lwt_a), .lc_ready(ready_a));

  mfe_lcd_charbuf_refresher #(.ROWS(4), .COLS(20), .ROW_W(2), .COL_W(6)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_row(wr_row_b), .wr_col(wr_col_b),
    .wr_data(wr_data_b), .refresh(refresh_b), .init_done(init_done_b), .busy(busy_b),
    .lc_cmd(cmd_b), .lc_dat(dat_b), .lc_vld(vld_b), .lc_lwt(lwt_b), .lc_ready(ready_b));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Downstream A: a byte seen valid+ready here is accepted at the next rising edge
  always @(negedge clk) begin
    if (rst_a) begin
      ready_a = 1'b1; pend_a = 0; cnt_a = 0;
    end else begin
      if (pend_a) begin
        ready_a = 1'b0; cnt_a = HOLD_A; pend_a = 0;
      end else if (!ready_a) begin
        cnt_a--;
        if (cnt_a == 0) ready_a = 1'b1;
      end
      if (vld_a && ready_a) begin
        pend_a = 1; cap_a++;
        if (exp_a.size() == 0)
          checkOutput("A unexpected byte", {22'd0, cmd_a, lwt_a, dat_a}, 32'h3ff);
        else
          checkOutput("A byte", {22'd0, cmd_a, lwt_a, dat_a}, {22'd0, exp_a.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      ready_b = 1'b1; pend_b = 0; cnt_b = 0;
    end else begin
      if (pend_b) begin
        ready_b = 1'b0; cnt_b = HOLD_B; pend_b = 0;
      end else if (!ready_b) begin
        cnt_b--;
        if (cnt_b == 0) ready_b = 1'b1;
      end
      if (vld_b && ready_b) begin
        pend_b = 1;
        if (cmd_b && !lwt_b) begin
          addr_b++;
          if (exp_b.size() == 0) checkOutput("B unexpected addr", {24'd0, dat_b}, 32'h1ff);
          else checkOutput("B addr", {24'd0, dat_b}, {24'd0, exp_b.pop_front()});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit on_b, input int row, input int col, input logic [7:0] data);
    if (!on_b) begin
      wr_en_a = 1'b1; wr_row_a = 2'(row); wr_col_a = 6'(col); wr_data_a = data;
      if (row < 2 && col < 16) model_a[row][col] = data;
      tick();
      wr_en_a = 1'b0;
    end else begin
      wr_en_b = 1'b1; wr_row_b = 2'(row); wr_col_b = 6'(col); wr_data_b = data;
      tick();
      wr_en_b = 1'b0;
    end
  endtask

  task automatic push_init_a();
    exp_a.push_back({2'b11, 8'h38});
    exp_a.push_back({2'b11, 8'h0C});
    exp_a.push_back({2'b11, 8'h01});
    exp_a.push_back({2'b11, 8'h06});
  endtask

  task automatic push_row_a(input int row);
    exp_a.push_back({2'b10, (row == 1) ? 8'hC0 : 8'h80});
    for (int c = 0; c < 16; c++) exp_a.push_back({2'b00, model_a[row][c]});
  endtask

  task automatic push_rows_b();
    exp_b.push_back(8'h80); exp_b.push_back(8'hC0);
    exp_b.push_back(8'h94); exp_b.push_back(8'hD4);
  endtask

  task automatic blank_a();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 16; c++) model_a[r][c] = 8'h20;
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 3000 && !(exp_a.size() == 0 && !busy_a); i++) tick();
    checkOutput({tag, " pending"}, 32'(exp_a.size()), 32'd0);
    checkOutput({tag, " busy"}, {31'd0, busy_a}, 32'd0);
  endtask

  task automatic drain_b(input string tag);
    for (int i = 0; i < 5000 && !(exp_b.size() == 0 && !busy_b); i++) tick();
    checkOutput({tag, " pending"}, 32'(exp_b.size()), 32'd0);
    checkOutput({tag, " busy"}, {31'd0, busy_b}, 32'd0);
  endtask

  task automatic wait_cap_a(input int target, input string tag);
    int i;
    for (i = 0; i < 1000 && cap_a < target; i++) tick();
    if (cap_a < target) checkOutput({tag, " timeout"}, 32'(cap_a), 32'(target));
  endtask

  initial begin
    int start;
    blank_a();
    repeat (3) tick();
    checkOutput("A rst vld", {31'd0, vld_a}, 32'd0);
    checkOutput("A rst cmd", {31'd0, cmd_a}, 32'd0);
    checkOutput("A rst dat", {24'd0, dat_a}, 32'd0);
    checkOutput("A rst lwt", {31'd0, lwt_a}, 32'd0);
    checkOutput("A rst init_done", {31'd0, init_done_a}, 32'd0);
    checkOutput("A rst busy", {31'd0, busy_a}, 32'd1);

    rst_a = 1'b0;
    push_init_a(); push_row_a(0); push_row_a(1);
    drain_a("A init");
    checkOutput("A init_done", {31'd0, init_done_a}, 32'd1);

    applyStimulus(0, 1, 3, 8'h41);
    push_row_a(1);
    drain_a("A single write");

    start = cap_a;
    applyStimulus(0, 2, 0, 8'h55);
    checkOutput("A oor row busy", {31'd0, busy_a}, 32'd0);
    applyStimulus(0, 0, 16, 8'h55);
    checkOutput("A oor col busy", {31'd0, busy_a}, 32'd0);
    repeat (20) tick();
    checkOutput("A oor no bytes", 32'(cap_a), 32'(start));

    applyStimulus(0, 0, 0, 8'h31);
    push_row_a(0);
    start = cap_a;
    wait_cap_a(start + 4, "A collision");
    applyStimulus(0, 0, 15, 8'h5A);
    exp_a[exp_a.size() - 1] = {2'b00, 8'h5A};
    push_row_a(0);
    drain_a("A collision");

    refresh_a = 1'b1; tick(); refresh_a = 1'b0;
    push_row_a(1); push_row_a(0);
    drain_a("A refresh");

    applyStimulus(0, 1, 5, 8'h77);
    push_row_a(1);
    start = cap_a;
    wait_cap_a(start + 6, "A mid-row");
    rst_a = 1'b1;
    exp_a.delete();
    tick();
    checkOutput("A vld after rst", {31'd0, vld_a}, 32'd0);
    checkOutput("A busy after rst", {31'd0, busy_a}, 32'd1);
    checkOutput("A init_done after rst", {31'd0, init_done_a}, 32'd0);
    tick();
    rst_a = 1'b0;
    blank_a();
    push_init_a(); push_row_a(0); push_row_a(1);
    drain_a("A reinit");
    checkOutput("A reinit init_done", {31'd0, init_done_a}, 32'd1);

    rst_b = 1'b0;
    push_rows_b();
    drain_b("B init");
    checkOutput("B init_done", {31'd0, init_done_b}, 32'd1);
    refresh_b = 1'b1; tick(); refresh_b = 1'b0;
    push_rows_b();
    drain_b("B refresh");

    applyStimulus(1, 1, 0, 8'h42);
    exp_b.push_back(8'hC0);
    start = addr_b;
    for (int i = 0; i < 500 && addr_b < start + 1; i++) tick();
    checkOutput("B row1 started", 32'(addr_b), 32'(start + 1));
    applyStimulus(1, 3, 0, 8'h43);
    applyStimulus(1, 1, 1, 8'h44);
    exp_b.push_back(8'hD4);
    exp_b.push_back(8'hC0);
    drain_b("B round robin");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
